// File: rtl/ila_pretrig_core.sv
// ila_pretrig_core
// Single-clock logic-analyser capture core with a programmable pre-trigger
// depth, an arm/abort capture state machine and trigger-relative read-back.
//
// Optional build macro: IOB_ILA_TIMESTAMP_EN
//   defined   -> a TIMESTAMP_W counter (cleared on arm_i) is stored in the
//                LSBs of every sample; signal_i sits above it.
//   undefined -> only signal_i is stored, no counter exists.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (beats cke_i)
//   cke_i             clock enable, low freezes every register
//   signal_i          probed signals (registered once before storage)
//   trigger_i         raw triggers (registered alongside signal_i)
//   trigger_mask_i    1 = bit takes part in the trigger reduction
//   trigger_type_i    0 = level, 1 = rising edge
//   negate_trigger_i  inverts a trigger bit before level/edge logic
//   reduce_and_i      0 = OR-reduce, 1 = AND-reduce of the active bits
//   arm_i, abort_i    restart capture / return to idle (abort wins)
//   pretrig_i         samples kept before the trigger sample
//   index_i           logical read index, 0 = oldest sample
//   value_select_i    DATA_W slice of the stored word
//   value_o           read data, two cycles after index_i/value_select_i
//   state_o           0 IDLE, 1 PRE, 2 WAIT, 3 POST/DONE
//   done_o            capture complete
//   n_samples_o       written samples, saturating at DEPTH
//   trigger_pos_o     physical address of the trigger sample
module ila_pretrig_core #(
    parameter int DATA_W      = 32,
    parameter int SIGNAL_W    = 64,
    parameter int TRIGGER_W   = 4,
    parameter int BUFFER_W    = 4,
    parameter int SEL_W       = 4,
    parameter int TIMESTAMP_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cke_i,
    input  logic [SIGNAL_W-1:0]  signal_i,
    input  logic [TRIGGER_W-1:0] trigger_i,
    input  logic [TRIGGER_W-1:0] trigger_mask_i,
    input  logic [TRIGGER_W-1:0] trigger_type_i,
    input  logic [TRIGGER_W-1:0] negate_trigger_i,
    input  logic                 reduce_and_i,
    input  logic                 arm_i,
    input  logic                 abort_i,
    input  logic [BUFFER_W-1:0]  pretrig_i,
    input  logic [BUFFER_W-1:0]  index_i,
    input  logic [SEL_W-1:0]     value_select_i,
    output logic [DATA_W-1:0]    value_o,
    output logic [1:0]           state_o,
    output logic                 done_o,
    output logic [BUFFER_W:0]    n_samples_o,
    output logic [BUFFER_W-1:0]  trigger_pos_o
);

    localparam int DEPTH = 1 << BUFFER_W;
`ifdef IOB_ILA_TIMESTAMP_EN
    localparam int STORED_W = SIGNAL_W + TIMESTAMP_W;
`else
    localparam int STORED_W = SIGNAL_W;
`endif
    localparam int NSLICE = (STORED_W + DATA_W - 1) / DATA_W;
    localparam int PAD_W  = NSLICE * DATA_W;
    localparam logic [BUFFER_W:0] DEPTH_C = (BUFFER_W + 1)'(DEPTH);

    // Low two bits are the software-visible state code; DONE shares code 3
    // with POST and is told apart by done_o.
    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_PRE  = 3'b001,
        S_WAIT = 3'b010,
        S_POST = 3'b011,
        S_DONE = 3'b111
    } state_t;

    state_t                state;
    logic [SIGNAL_W-1:0]   sig_r;
    logic [TRIGGER_W-1:0]  trig_r;
    logic [TRIGGER_W-1:0]  v_prev;
    logic [BUFFER_W-1:0]   pretrig_l;
    logic [BUFFER_W-1:0]   wr_ptr;
    logic [BUFFER_W:0]     cnt;
    logic [BUFFER_W:0]     post;
    logic [BUFFER_W-1:0]   trig_pos;
    logic                  done;

    logic [STORED_W-1:0]   mem [DEPTH];
    logic [STORED_W-1:0]   wr_data;
    logic                  wr_en;
    logic [STORED_W-1:0]   rd_word;
    logic [SEL_W-1:0]      sel_r;
    logic [DATA_W-1:0]     value;
    logic [BUFFER_W-1:0]   rd_addr;
    logic [PAD_W-1:0]      padded;
    logic [DATA_W-1:0]     slice_val;

    logic [TRIGGER_W-1:0]  v;
    logic [TRIGGER_W-1:0]  active;
    logic                  hit;
    logic [BUFFER_W:0]     post_tgt;

    // Trigger qualification runs on the registered copy so the trigger and
    // the sample written in the same cycle belong together.
    assign v      = trig_r ^ negate_trigger_i;
    assign active = (trigger_type_i & v & ~v_prev) | (~trigger_type_i & v);
    always_comb begin
        hit = 1'b0;
        if (|trigger_mask_i)
            hit = reduce_and_i ? &(active | ~trigger_mask_i)
                               : |(active & trigger_mask_i);
    end

    // Samples from the trigger onwards (trigger sample included).
    assign post_tgt = DEPTH_C - {1'b0, pretrig_l};

`ifdef IOB_ILA_TIMESTAMP_EN
    logic [TIMESTAMP_W-1:0] ts;
    always_ff @(posedge clk_i) begin
        if (rst_i)
            ts <= '0;
        else if (cke_i)
            ts <= arm_i ? '0 : ts + 1'b1;
    end
    assign wr_data = {sig_r, ts};
`else
    assign wr_data = sig_r;
`endif

    assign wr_en = cke_i && !rst_i &&
                   (state == S_PRE || state == S_WAIT || state == S_POST);

    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            sig_r     <= '0;
            trig_r    <= '0;
            v_prev    <= '0;
            pretrig_l <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            post      <= '0;
            trig_pos  <= '0;
            done      <= 1'b0;
        end else if (cke_i) begin
            sig_r  <= signal_i;
            trig_r <= trigger_i;
            v_prev <= v;
            if (abort_i) begin
                state <= S_IDLE;
                done  <= 1'b0;
            end else if (arm_i) begin
                pretrig_l <= pretrig_i;
                wr_ptr    <= '0;
                cnt       <= '0;
                post      <= '0;
                done      <= 1'b0;
                state     <= (pretrig_i == '0) ? S_WAIT : S_PRE;
            end else begin
                case (state)
                    S_PRE: begin
                        wr_ptr <= wr_ptr + 1'b1;
                        cnt    <= cnt + 1'b1;
                        if (cnt + 1'b1 == {1'b0, pretrig_l})
                            state <= S_WAIT;
                    end
                    S_WAIT: begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (cnt != DEPTH_C)
                            cnt <= cnt + 1'b1;
                        if (hit) begin
                            trig_pos <= wr_ptr;
                            post     <= (BUFFER_W + 1)'(1);
                            if (post_tgt == (BUFFER_W + 1)'(1)) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (cnt != DEPTH_C)
                            cnt <= cnt + 1'b1;
                        post <= post + 1'b1;
                        if (post + 1'b1 == post_tgt) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Once done, index 0 maps to the oldest kept pre-trigger sample.
    assign rd_addr = (state == S_DONE) ? (trig_pos - pretrig_l + index_i)
                                       : index_i;
    assign padded  = PAD_W'(rd_word);

    always_comb begin
        slice_val = '0;
        for (int s = 0; s < NSLICE; s++)
            if (sel_r == SEL_W'(s))
                slice_val = padded[s*DATA_W +: DATA_W];
    end

    // RAM read register, then slice-select output register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_word <= '0;
            sel_r   <= '0;
            value   <= '0;
        end else if (cke_i) begin
            rd_word <= mem[rd_addr];
            sel_r   <= value_select_i;
            value   <= slice_val;
        end
    end

    assign value_o       = value;
    assign state_o       = state[1:0];
    assign done_o        = done;
    assign n_samples_o   = cnt;
    assign trigger_pos_o = trig_pos;

endmodule

// File: tb/tb_ila_pretrig_core.sv
module tb_ila_pretrig_core;

    localparam int DATA_W = 32, SIGNAL_W = 40, TRIGGER_W = 4;
    localparam int BUFFER_W = 4, SEL_W = 4, TIMESTAMP_W = 16;

    logic                 clk = 1'b0;
    logic                 rst, cke, reduce_and, arm, abort;
    logic [SIGNAL_W-1:0]  signal;
    logic [TRIGGER_W-1:0] trigger, mask, ttype, negate;
    logic [BUFFER_W-1:0]  pretrig, index;
    logic [SEL_W-1:0]     vsel;
    logic [DATA_W-1:0]    value;
    logic [1:0]           state;
    logic                 done;
    logic [BUFFER_W:0]    n_samples;
    logic [BUFFER_W-1:0]  trigger_pos;

    int errors = 0;
    int checks = 0;
    int c = 0;

    always #5 clk = ~clk;

    ila_pretrig_core #(
        .DATA_W(DATA_W), .SIGNAL_W(SIGNAL_W), .TRIGGER_W(TRIGGER_W),
        .BUFFER_W(BUFFER_W), .SEL_W(SEL_W), .TIMESTAMP_W(TIMESTAMP_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .cke_i(cke),
        .signal_i(signal), .trigger_i(trigger),
        .trigger_mask_i(mask), .trigger_type_i(ttype),
        .negate_trigger_i(negate), .reduce_and_i(reduce_and),
        .arm_i(arm), .abort_i(abort), .pretrig_i(pretrig),
        .index_i(index), .value_select_i(vsel),
        .value_o(value), .state_o(state), .done_o(done),
        .n_samples_o(n_samples), .trigger_pos_o(trigger_pos)
    );

    // One clock: present sample c, let a rising edge pass, advance c.
    task automatic step();
        signal = {8'h5A, 32'(c)};
        @(negedge clk);
        c++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (n_samples !== '0) begin errors++; $display("FAIL reset_nsamp got %0d want 0", n_samples); end
        checks++; if (trigger_pos !== '0) begin errors++; $display("FAIL reset_tpos got %0d want 0", trigger_pos); end
        checks++; if (value !== '0) begin errors++; $display("FAIL reset_value got %0h want 0", value); end
        rst = 1'b0;
    endtask

    task automatic test_level();
        int guard = 0;
        mask = 4'b0001; ttype = 4'b0000; negate = 4'b0000; reduce_and = 1'b0;
        pretrig = 4'd4; trigger = '0; c = 20;
        arm = 1'b1; step(); arm = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL level_pre got %0d want 1", state); end
        while (!done && guard < 100) begin
            trigger = {3'b000, c == 40};
            step();
            guard++;
        end
        trigger = '0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL level_done got %0b want 1", done); end
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL level_state got %0d want 3", state); end
        checks++; if (trigger_pos !== 4'd4) begin errors++; $display("FAIL level_tpos got %0d want 4", trigger_pos); end
        checks++; if (n_samples !== 5'd16) begin errors++; $display("FAIL level_nsamp got %0d want 16", n_samples); end
        vsel = '0;
        for (int k = 0; k < 16; k++) begin
            index = 4'(k);
            @(negedge clk); @(negedge clk);
            checks++;
            if (value !== 32'(36 + k)) begin
                errors++; $display("FAIL level_read[%0d] got %0d want %0d", k, value, 36 + k);
            end
        end
    endtask

    task automatic test_slices();
        index = 4'd0; vsel = 4'd0;
        @(negedge clk); @(negedge clk);
        checks++; if (value !== 32'd36) begin errors++; $display("FAIL slice0 got %0h want 24", value); end
        index = 4'd5;
        @(negedge clk);
        checks++; if (value !== 32'd36) begin errors++; $display("FAIL latency_1cyc got %0d want 36", value); end
        @(negedge clk);
        checks++; if (value !== 32'd41) begin errors++; $display("FAIL latency_2cyc got %0d want 41", value); end
        vsel = 4'd1;
        @(negedge clk); @(negedge clk);
        checks++; if (value !== 32'h0000_005A) begin errors++; $display("FAIL slice1 got %0h want 5a", value); end
        vsel = 4'd2;
        @(negedge clk); @(negedge clk);
        checks++; if (value !== 32'd0) begin errors++; $display("FAIL slice2 got %0h want 0", value); end
        vsel = 4'd15;
        @(negedge clk); @(negedge clk);
        checks++; if (value !== 32'd0) begin errors++; $display("FAIL slice15 got %0h want 0", value); end
        vsel = 4'd0;
    endtask

    task automatic test_edge_pretrig0();
        int guard = 0;
        trigger = '0; mask = 4'b0010; ttype = 4'b0010; reduce_and = 1'b1;
        pretrig = 4'd0;
        step();
        c = 80;
        arm = 1'b1; step(); arm = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL edge_skip_pre got %0d want 2", state); end
        while (!done && guard < 100) begin
            trigger = (c >= 100) ? 4'b0010 : 4'b0000;
            step();
            guard++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL edge_done got %0b want 1", done); end
        checks++; if (trigger_pos !== 4'd4) begin errors++; $display("FAIL edge_tpos got %0d want 4", trigger_pos); end
        checks++; if (n_samples !== 5'd16) begin errors++; $display("FAIL edge_nsamp got %0d want 16", n_samples); end
        index = 4'd0;
        @(negedge clk); @(negedge clk);
        checks++; if (value !== 32'd100) begin errors++; $display("FAIL edge_idx0 got %0d want 100", value); end
        index = 4'd15;
        @(negedge clk); @(negedge clk);
        checks++; if (value !== 32'd115) begin errors++; $display("FAIL edge_idx15 got %0d want 115", value); end
    endtask

    task automatic test_pretrig_max();
        mask = 4'b0001; ttype = 4'b0000; reduce_and = 1'b0;
        pretrig = 4'd15; trigger = 4'b0001; c = 200;
        arm = 1'b1; step(); arm = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL pmax_pre got %0d want 1", state); end
        repeat (14) step();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL pmax_pre_ignore got %0d want 1", state); end
        step();
        checks++; if (state !== 2'd2 || done !== 1'b0) begin errors++; $display("FAIL pmax_wait got %0d/%0b want 2/0", state, done); end
        step();
        checks++; if (done !== 1'b1 || state !== 2'd3) begin errors++; $display("FAIL pmax_done got %0d/%0b want 3/1", state, done); end
        checks++; if (trigger_pos !== 4'd15) begin errors++; $display("FAIL pmax_tpos got %0d want 15", trigger_pos); end
        index = 4'd0;
        @(negedge clk); @(negedge clk);
        checks++; if (value !== 32'd200) begin errors++; $display("FAIL pmax_idx0 got %0d want 200", value); end
        index = 4'd15;
        @(negedge clk); @(negedge clk);
        checks++; if (value !== 32'd215) begin errors++; $display("FAIL pmax_idx15 got %0d want 215", value); end
    endtask

    task automatic test_abort_arm();
        mask = 4'b0001; ttype = 4'b0000; reduce_and = 1'b0;
        pretrig = 4'd2; trigger = '0;
        arm = 1'b1; step(); arm = 1'b0;
        step(); step();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL abort_wait got %0d want 2", state); end
        trigger = 4'b0001; step();
        trigger = 4'b0000; step();
        checks++; if (state !== 2'd3 || done !== 1'b0) begin errors++; $display("FAIL abort_post got %0d/%0b want 3/0", state, done); end
        abort = 1'b1; step(); abort = 1'b0;
        checks++; if (state !== 2'd0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle got %0d/%0b want 0/0", state, done); end
        arm = 1'b1; step(); arm = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL rearm_pre got %0d want 1", state); end
        arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL arm_abort got %0d want 0", state); end
        pretrig = 4'd15; trigger = 4'b0001;
        arm = 1'b1; step(); arm = 1'b0;
        repeat (16) step();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_redone got %0b want 1", done); end
        arm = 1'b1; step(); arm = 1'b0;
        checks++; if (state !== 2'd1 || done !== 1'b0) begin errors++; $display("FAIL arm_in_done got %0d/%0b want 1/0", state, done); end
    endtask

    task automatic test_cke();
        pretrig = 4'd0; mask = 4'b0000; reduce_and = 1'b1; trigger = 4'hF;
        arm = 1'b1; step(); arm = 1'b0;
        checks++; if (state !== 2'd2 || n_samples !== 5'd0) begin errors++; $display("FAIL cke_arm got %0d/%0d want 2/0", state, n_samples); end
        repeat (3) step();
        checks++; if (n_samples !== 5'd3) begin errors++; $display("FAIL cke_run got %0d want 3", n_samples); end
        cke = 1'b0;
        repeat (5) step();
        checks++; if (n_samples !== 5'd3 || state !== 2'd2) begin errors++; $display("FAIL cke_frozen got %0d/%0d want 3/2", n_samples, state); end
        cke = 1'b1;
        repeat (20) step();
        checks++; if (n_samples !== 5'd16 || state !== 2'd2) begin errors++; $display("FAIL cke_sat got %0d/%0d want 16/2", n_samples, state); end
    endtask

    task automatic test_reset_cke_low();
        index = 4'd3; vsel = 4'd0;
        step(); step();
        cke = 1'b0; rst = 1'b1;
        step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rstcke_state got %0d want 0", state); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstcke_done got %0b want 0", done); end
        checks++; if (n_samples !== '0) begin errors++; $display("FAIL rstcke_nsamp got %0d want 0", n_samples); end
        checks++; if (trigger_pos !== '0) begin errors++; $display("FAIL rstcke_tpos got %0d want 0", trigger_pos); end
        checks++; if (value !== '0) begin errors++; $display("FAIL rstcke_value got %0h want 0", value); end
        rst = 1'b0; cke = 1'b1;
    endtask

    initial begin
        rst = 1'b1; cke = 1'b1; reduce_and = 1'b0; arm = 1'b0; abort = 1'b0;
        signal = '0; trigger = '0; mask = '0; ttype = '0; negate = '0;
        pretrig = '0; index = '0; vsel = '0;
        test_reset();
        test_level();
        test_slices();
        test_edge_pretrig0();
        test_pretrig_max();
        test_abort_arm();
        test_cke();
        test_reset_cke_low();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
